mem_line_arbiter: RTL
=====================

// Module: mem_line_arbiter
// PURPOSE
//   Shares the single 256-bit line-wide memory port between the instruction cache (line reads only)
//   and the data cache (line reads and write-backs). It grants one requester at a time and drives the
//   memory strobes from registers. It routes mem_ack_i and the read line back to the granted requester
//   only. Sits between both caches and the memory controller.
// PARAMETERS
//   ADDR_WIDTH  32   byte address width, all address ports
//   LINE_BITS   256  cache line width, all data ports
//   OFF_BITS    5    log2(LINE_BITS/8); low address bits forced to 0 on mem_addr_o
// PORTS
//   clk         in   1           system clock, all logic on posedge
//   rst         in   1           reset, synchronous, active-low (rst==0 at posedge resets)
//   i_addr_i    in   ADDR_WIDTH  icache line address
//   i_rd_i      in   1           icache read request, held until i_ack_o
//   i_data_o    out  LINE_BITS   line returned to icache
//   i_ack_o     out  1           icache transfer done (1 cycle)
//   d_addr_i    in   ADDR_WIDTH  dcache line address
//   d_rd_i      in   1           dcache read request, held until d_ack_o
//   d_wr_i      in   1           dcache write request, held until d_ack_o
//   d_data_i    in   LINE_BITS   dcache write-back line
//   d_data_o    out  LINE_BITS   line returned to dcache
//   d_ack_o     out  1           dcache transfer done (1 cycle)
//   mem_addr_o  out  ADDR_WIDTH  registered memory line address
//   mem_rd_o    out  1           registered memory read strobe
//   mem_wr_o    out  1           registered memory write strobe
//   mem_data_o  out  LINE_BITS   registered write data
//   mem_data_i  in   LINE_BITS   memory read data, valid with mem_ack_i
//   mem_ack_i   in   1           memory transfer done
//   busy_o      out  1           1 whenever state != IDLE
// BEHAVIOUR
//   - Reset (rst==0): state=IDLE, mem_addr_o=0, mem_rd_o=0, mem_wr_o=0, mem_data_o=0, busy_o=0.
//     i_ack_o=d_ack_o=0. last_grant=I. An in-flight transfer is abandoned and no ack is issued.
//   - FSM states: IDLE, GNT_I, GNT_D.
//   - IDLE: sample requests. d_req = d_rd_i|d_wr_i. On the next edge, go to GNT_I or GNT_D. Latch
//     addr[ADDR_WIDTH-1:OFF_BITS] into mem_addr_o with the low OFF_BITS set to 0.
//     - GNT_I: mem_rd_o<=1.
//     - GNT_D: mem_wr_o<=d_wr_i, mem_rd_o<=~d_wr_i, mem_data_o<=d_data_i.
//     - If d_rd_i and d_wr_i are both 1, the request is treated as a write.
//   - Latency: a request visible in IDLE at cycle N gives a strobe high in cycle N+1.
//   - GNT_x: strobes, address and data are held stable until mem_ack_i.
//     - In the cycle mem_ack_i=1, x_ack_o=1 (combinational) and x_data_o=mem_data_i. The other
//       requester's ack stays 0.
//     - Next edge: strobes<=0, mem_addr_o<=0, state<=IDLE, last_grant<=x.
//   - Back-to-back: a requester drops its request on the ack edge. The next grant is earliest 1 cycle
//     after the ack, with strobes low for at least 1 cycle between transfers.
//   - i_data_o and d_data_o are always driven with mem_data_i. Consumers qualify them with their ack.
//   - mem_ack_i in IDLE is ignored; no ack is forwarded.
//   - A request withdrawn before its ack is a protocol violation. The grant still runs to mem_ack_i,
//     and the ack is forwarded regardless.
//   - Requests arriving during a grant wait; no queueing beyond the held request lines.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN defined: when both request in IDLE, grant the one opposite last_grant (after
//     reset, D wins first).
//   ARB_ROUND_ROBIN_EN undefined: fixed priority, D over I. last_grant is still kept but unused.
//   A single request is granted immediately in both modes.
// TESTING
//   1. i_rd_i=1, addr 0x0000_1234; mem_ack_i 3 cycles after mem_rd_o rises, mem_data_i=pattern A
//      -> mem_addr_o=0x0000_1220, mem_rd_o=1 from N+1, i_ack_o=1 for 1 cycle with i_data_o=A,
//      d_ack_o=0.
//   2. d_wr_i=1, addr 0x8000_0040, d_data_i=B -> mem_wr_o=1, mem_rd_o=0, mem_data_o=B held until
//      ack; d_ack_o pulses once.
//   3. i_rd_i and d_rd_i both rise in the same cycle, held through 2 transfers each
//      -> fixed: D,D,... starves I. RR: D,I,D,I. Strobe gap of at least 1 cycle every time.
//   4. rst=0 for 1 cycle mid-GNT_D, then mem_ack_i=1 -> all strobes 0 after the edge, no ack
//      forwarded, state IDLE, busy_o=0.
//   5. mem_ack_i=1 pulses while IDLE with no request -> no ack out, strobes stay 0.
//   6. d_rd_i=d_wr_i=1, addr 0x40 -> mem_wr_o=1, mem_rd_o=0.

Source files
------------

// File: rtl/mem_line_arbiter_if.sv
// Bundle of the icache, dcache and memory-side signals of the line arbiter.
// Latency: none (wires only).
// Backpressure: requests are held by the caches until their ack; memory completes with mem_ack_i.
interface mem_line_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256
);
    // icache side
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic                  i_rd_i;
    logic [LINE_BITS-1:0]  i_data_o;
    logic                  i_ack_o;
    // dcache side
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic                  d_rd_i;
    logic                  d_wr_i;
    logic [LINE_BITS-1:0]  d_data_i;
    logic [LINE_BITS-1:0]  d_data_o;
    logic                  d_ack_o;
    // memory side
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_rd_o;
    logic                  mem_wr_o;
    logic [LINE_BITS-1:0]  mem_data_o;
    logic [LINE_BITS-1:0]  mem_data_i;
    logic                  mem_ack_i;
    // status
    logic                  busy_o;

    // arbiter view
    modport slave (
        input  i_addr_i, i_rd_i, d_addr_i, d_rd_i, d_wr_i, d_data_i, mem_data_i, mem_ack_i,
        output i_data_o, i_ack_o, d_data_o, d_ack_o, mem_addr_o, mem_rd_o, mem_wr_o,
               mem_data_o, busy_o
    );

    // caches plus memory controller view
    modport master (
        output i_addr_i, i_rd_i, d_addr_i, d_rd_i, d_wr_i, d_data_i, mem_data_i, mem_ack_i,
        input  i_data_o, i_ack_o, d_data_o, d_ack_o, mem_addr_o, mem_rd_o, mem_wr_o,
               mem_data_o, busy_o
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// Shares one line-wide memory port between icache (reads) and dcache (reads/write-backs); ARB_ROUND_ROBIN_EN selects round-robin over fixed D>I priority.
// Latency: request seen in IDLE at cycle N drives registered strobes in N+1; ack forwarded combinationally with mem_ack_i.
// Backpressure: one grant at a time; other requester holds its request line until the grant returns to IDLE.
module mem_line_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BITS  = 256,
    parameter int OFF_BITS   = 5
) (
    input logic clk,
    input logic rst,
    mem_line_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  mem_rd_q;
    logic                  mem_wr_q;
    logic [LINE_BITS-1:0]  mem_data_q;
    logic                  last_grant_d_q;   // 1: dcache had the last grant, 0: icache
    logic                  i_req;
    logic                  d_req;
    logic                  both_pick_d;

    assign i_req = bus.i_rd_i;
    assign d_req = bus.d_rd_i | bus.d_wr_i;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the requester that did not win last time goes next.
    assign both_pick_d = ~last_grant_d_q;
`else
    // Fixed priority: dcache always wins a tie; last_grant is tracked but has no effect.
    assign both_pick_d = last_grant_d_q | 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: pick a requester in IDLE, return to IDLE on the memory ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && (!i_req || both_pick_d)) state_d = GNT_D;
                else if (i_req)                       state_d = GNT_I;
            end
            GNT_I, GNT_D: begin
                if (bus.mem_ack_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ack steered only to the granted requester, busy outside IDLE
    always_comb begin
        bus.i_ack_o = 1'b0;
        bus.d_ack_o = 1'b0;
        bus.busy_o  = (state_q != IDLE);
        if (state_q == GNT_I) bus.i_ack_o = bus.mem_ack_i;
        if (state_q == GNT_D) bus.d_ack_o = bus.mem_ack_i;
    end

    // Memory-side registers: loaded on grant, held during it, cleared on the ack edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr_q     <= '0;
            mem_rd_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_data_q     <= '0;
            last_grant_d_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (state_d == GNT_D) begin
                        // Read and write together counts as a write-back.
                        mem_addr_q <= bus.d_addr_i & ~OFF_MASK;
                        mem_wr_q   <= bus.d_wr_i;
                        mem_rd_q   <= ~bus.d_wr_i;
                        mem_data_q <= bus.d_data_i;
                    end else if (state_d == GNT_I) begin
                        mem_addr_q <= bus.i_addr_i & ~OFF_MASK;
                        mem_rd_q   <= 1'b1;
                        mem_wr_q   <= 1'b0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (bus.mem_ack_i) begin
                        mem_addr_q     <= '0;
                        mem_rd_q       <= 1'b0;
                        mem_wr_q       <= 1'b0;
                        last_grant_d_q <= (state_q == GNT_D);
                    end
                end
                default: begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr_o = mem_addr_q;
    assign bus.mem_rd_o   = mem_rd_q;
    assign bus.mem_wr_o   = mem_wr_q;
    assign bus.mem_data_o = mem_data_q;
    // Return data goes to both caches; each qualifies it with its own ack.
    assign bus.i_data_o   = bus.mem_data_i;
    assign bus.d_data_o   = bus.mem_data_i;
endmodule
